// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Asynchronous serial receiver with a small first-word-fall-through receive
// queue. Each bit is oversampled on a programmable tick and decided by a
// 3-sample majority vote around the bit centre. Framing and parity are checked
// and the result flags travel with each word through the queue. A word that
// completes while the queue is full is dropped and raises a sticky overrun.
//
// Parameters
//   data_bits   payload bits per frame (5..9)
//   oversample  sample ticks per bit (even, >= 4)
//   div_bits    width of baud_div
//   parity_mode 0 = none, 1 = even, 2 = odd
//   stop_bits   1 or 2
//   fifo_depth  queue entries (power of 2, >= 2)
//
// Ports
//   sysclk      system clock, rising edge
//   rst         synchronous active-high reset
//   rxd         asynchronous serial input, idle high
//   baud_div    tick period is baud_div+1 sysclk cycles (change only while idle)
//   rd_en       pop the queue head (ignored when empty)
//   clr_err     clear the sticky overrun flag
//   RDR         head data (0 when empty)
//   rxd_readyH  queue non-empty
//   parity_err  parity error flag of the head entry
//   frame_err   stop-bit error flag of the head entry
//   overrun     sticky: a completed word was dropped on a full queue
//   fifo_count  number of queued entries
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int unsigned data_bits   = 8,
   parameter int unsigned oversample  = 16,
   parameter int unsigned div_bits    = 16,
   parameter int unsigned parity_mode = 0,
   parameter int unsigned stop_bits   = 1,
   parameter int unsigned fifo_depth  = 4
) (
   input  logic                          sysclk,
   input  logic                          rst,
   input  logic                          rxd,
   input  logic [div_bits-1:0]           baud_div,
   input  logic                          rd_en,
   input  logic                          clr_err,
   output logic [data_bits-1:0]          RDR,
   output logic                          rxd_readyH,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overrun,
   output logic [$clog2(fifo_depth):0]   fifo_count
);

   // --------------------------------------------------------------------------
   // Derived constants
   // --------------------------------------------------------------------------
   localparam int unsigned SW = $clog2(oversample);
   localparam int unsigned BW = $clog2(data_bits);
   localparam int unsigned AW = $clog2(fifo_depth);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = data_bits + 2;

   // Sampling ticks around the bit centre; the last one is the decision point.
   localparam logic [SW-1:0] SMP_A    = SW'(oversample / 2 - 1);
   localparam logic [SW-1:0] SMP_B    = SW'(oversample / 2);
   localparam logic [SW-1:0] SMP_C    = SW'(oversample / 2 + 1);
   localparam logic [SW-1:0] SMP_LAST = SW'(oversample - 1);

   localparam logic [BW-1:0] BIT_LAST  = BW'(data_bits - 1);
   localparam logic          STOP_LAST = (stop_bits == 2);
   localparam logic          PAR_EN    = (parity_mode != 0);
   localparam logic          PAR_ODD   = (parity_mode == 2);
   localparam logic [CW-1:0] CNT_FULL  = CW'(fifo_depth);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // --------------------------------------------------------------------------
   // Input synchroniser and falling-edge detect
   // --------------------------------------------------------------------------
   logic rxd_s1_q;
   logic rxd_s2_q;
   logic rxd_prev_q;
   logic start_edge;

   state_t state_q;

   // NOTE: clocked state is always written with <= so every flop samples the
   // pre-edge value of its neighbours, regardless of statement order.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         rxd_s1_q   <= 1'b1;
         rxd_s2_q   <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_s1_q   <= rxd;
         rxd_s2_q   <= rxd_s1_q;
         rxd_prev_q <= rxd_s2_q;
      end
   end

   // Only a 1->0 transition seen while idle starts a frame.
   assign start_edge = (state_q == S_IDLE) && rxd_prev_q && !rxd_s2_q;

   // --------------------------------------------------------------------------
   // Tick generator and per-bit sample counter
   // --------------------------------------------------------------------------
   logic [div_bits-1:0] tick_cnt_q, tick_cnt_d;
   logic                tick;
   logic [SW-1:0]       samp_q, samp_d;

   // NOTE: every variable assigned in always_comb receives a default first so
   // no path leaves it holding a value, which would infer a latch.
   always_comb begin
      tick       = (tick_cnt_q == '0);
      tick_cnt_d = tick_cnt_q - div_bits'(1);
      // Reloading on the start edge aligns the sample grid to the start bit.
      if (start_edge || tick) begin
         tick_cnt_d = baud_div;
      end

      samp_d = samp_q;
      if (start_edge) begin
         samp_d = '0;
      end else if (tick && (state_q != S_IDLE)) begin
         samp_d = (samp_q == SMP_LAST) ? '0 : samp_q + SW'(1);
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         tick_cnt_q <= '0;
         samp_q     <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         samp_q     <= samp_d;
      end
   end

   // --------------------------------------------------------------------------
   // Majority vote: two stored samples plus the live one at the decision tick
   // --------------------------------------------------------------------------
   logic smp_a_q;
   logic smp_b_q;
   logic decide;
   logic maj;

   always_ff @(posedge sysclk) begin
      if (rst) begin
         smp_a_q <= 1'b1;
         smp_b_q <= 1'b1;
      end else if (tick && (state_q != S_IDLE)) begin
         if (samp_q == SMP_A) smp_a_q <= rxd_s2_q;
         if (samp_q == SMP_B) smp_b_q <= rxd_s2_q;
      end
   end

   assign decide = tick && (state_q != S_IDLE) && (samp_q == SMP_C);
   assign maj    = (smp_a_q & smp_b_q) | (smp_a_q & rxd_s2_q) | (smp_b_q & rxd_s2_q);

   // --------------------------------------------------------------------------
   // Frame FSM
   // --------------------------------------------------------------------------
   logic [BW-1:0]        bit_cnt_q;
   logic                 stop_cnt_q;
   logic [data_bits-1:0] data_q;
   logic                 pe_q;
   logic                 fe_q;
   logic                 push_q;

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         data_q     <= '0;
         pe_q       <= 1'b0;
         fe_q       <= 1'b0;
         push_q     <= 1'b0;
      end else begin
         push_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start_edge) begin
                  state_q <= S_START;
                  pe_q    <= 1'b0;
                  fe_q    <= 1'b0;
               end
            end

            S_START: begin
               if (decide) begin
                  // A start bit that votes high was noise; resume hunting.
                  if (maj) begin
                     state_q <= S_IDLE;
                  end else begin
                     state_q   <= S_DATA;
                     bit_cnt_q <= '0;
                  end
               end
            end

            S_DATA: begin
               if (decide) begin
                  data_q <= {maj, data_q[data_bits-1:1]};
                  if (bit_cnt_q == BIT_LAST) begin
                     state_q    <= PAR_EN ? S_PARITY : S_STOP;
                     stop_cnt_q <= 1'b0;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BW'(1);
                  end
               end
            end

            S_PARITY: begin
               if (decide) begin
                  // XOR over data and parity bit is 0 for good even parity,
                  // 1 for good odd parity.
                  pe_q    <= (^data_q) ^ maj ^ PAR_ODD;
                  state_q <= S_STOP;
               end
            end

            S_STOP: begin
               if (decide) begin
                  if (!maj) fe_q <= 1'b1;
                  if (stop_cnt_q == STOP_LAST) begin
                     push_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     stop_cnt_q <= 1'b1;
                  end
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Receive queue: {fe, pe, data} per entry, head visible combinationally
   // --------------------------------------------------------------------------
   logic [EW-1:0] mem_q [fifo_depth];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overrun_q, overrun_d;
   logic          empty;
   logic          full;
   logic          pop;
   logic          wr;
   logic [EW-1:0] head;

   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == CNT_FULL);
      pop   = rd_en && !empty;
      // A pop in the same cycle frees the slot a full queue needs.
      wr    = push_q && (!full || pop);

      wr_ptr_d = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

      count_d = count_q;
      if (wr && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!wr && pop) begin
         count_d = count_q - CW'(1);
      end

      // Setting wins over clearing so a drop is never lost.
      overrun_d = overrun_q;
      if (push_q && !wr) begin
         overrun_d = 1'b1;
      end else if (clr_err) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // NOTE: the storage array has no reset; stale contents are never visible
   // because the outputs are forced to 0 while the queue is empty.
   always_ff @(posedge sysclk) begin
      if (wr) begin
         mem_q[wr_ptr_q] <= {fe_q, pe_q, data_q};
      end
   end

   assign head = mem_q[rd_ptr_q];

   always_comb begin
      RDR        = '0;
      parity_err = 1'b0;
      frame_err  = 1'b0;
      if (!empty) begin
         RDR        = head[data_bits-1:0];
         parity_err = head[data_bits];
         frame_err  = head[data_bits+1];
      end
   end

   assign rxd_readyH = !empty;
   assign overrun    = overrun_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Three receivers share clock, reset and baud divisor: u_8n1 (no parity, one
// stop bit), u_8e1 (even parity) and u_8n2 (two stop bits). Each has its own
// serial line and pop strobe. baud_div = 3 with oversample 16 gives 64-cycle
// bits. Inputs change on the falling clock edge, outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

   localparam int BIT_CYC = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic [15:0]     baud_div;
   logic            clr_err;
   logic [2:0]      rxd_v;
   logic [2:0]      rd_en_v;
   logic [2:0][7:0] rdr_v;
   logic [2:0]      ready_v;
   logic [2:0]      pe_v;
   logic [2:0]      fe_v;
   logic [2:0]      ovr_v;
   logic [2:0][2:0] cnt_v;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.parity_mode(0), .stop_bits(1)) u_8n1 (
      .sysclk(clk), .rst(rst), .rxd(rxd_v[0]), .baud_div(baud_div),
      .rd_en(rd_en_v[0]), .clr_err(clr_err), .RDR(rdr_v[0]),
      .rxd_readyH(ready_v[0]), .parity_err(pe_v[0]), .frame_err(fe_v[0]),
      .overrun(ovr_v[0]), .fifo_count(cnt_v[0]));

   uart_rx_fifo #(.parity_mode(1), .stop_bits(1)) u_8e1 (
      .sysclk(clk), .rst(rst), .rxd(rxd_v[1]), .baud_div(baud_div),
      .rd_en(rd_en_v[1]), .clr_err(1'b0), .RDR(rdr_v[1]),
      .rxd_readyH(ready_v[1]), .parity_err(pe_v[1]), .frame_err(fe_v[1]),
      .overrun(ovr_v[1]), .fifo_count(cnt_v[1]));

   uart_rx_fifo #(.parity_mode(0), .stop_bits(2)) u_8n2 (
      .sysclk(clk), .rst(rst), .rxd(rxd_v[2]), .baud_div(baud_div),
      .rd_en(rd_en_v[2]), .clr_err(1'b0), .RDR(rdr_v[2]),
      .rxd_readyH(ready_v[2]), .parity_err(pe_v[2]), .frame_err(fe_v[2]),
      .overrun(ovr_v[2]), .fifo_count(cnt_v[2]));

   typedef struct {
      int         sel;
      logic [7:0] data;
      bit         par_en;
      logic       par_bit;
      logic       stop0;
      logic       stop1;
      bit         two_stop;
      logic [7:0] exp_rdr;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   vec_t vecs [9];

   function automatic vec_t mk(input int sel, input logic [7:0] data,
                               input bit par_en, input logic par_bit,
                               input logic stop0, input logic stop1,
                               input bit two_stop, input logic [7:0] exp_rdr,
                               input logic exp_pe, input logic exp_fe);
      vec_t v;
      v.sel = sel;       v.data = data;       v.par_en = par_en;
      v.par_bit = par_bit; v.stop0 = stop0;   v.stop1 = stop1;
      v.two_stop = two_stop; v.exp_rdr = exp_rdr;
      v.exp_pe = exp_pe; v.exp_fe = exp_fe;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // One bit period on line sel; optionally a 4-cycle low glitch at the centre.
   task automatic drive_bit(input int sel, input logic val, input bit glitch);
      rxd_v[sel] = val;
      if (glitch) begin
         repeat (34) @(negedge clk);
         rxd_v[sel] = 1'b0;
         repeat (4) @(negedge clk);
         rxd_v[sel] = val;
         repeat (BIT_CYC - 38) @(negedge clk);
      end else begin
         repeat (BIT_CYC) @(negedge clk);
      end
   endtask

   task automatic send_frame(input int sel, input logic [7:0] data,
                             input bit par_en, input logic par_bit,
                             input logic stop0, input logic stop1,
                             input bit two_stop, input int glitch_bit);
      drive_bit(sel, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(sel, data[i], i == glitch_bit);
      if (par_en) drive_bit(sel, par_bit, 1'b0);
      drive_bit(sel, stop0, 1'b0);
      if (two_stop) drive_bit(sel, stop1, 1'b0);
      drive_bit(sel, 1'b1, 1'b0);
   endtask

   task automatic send_8n1(input logic [7:0] data);
      send_frame(0, data, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
   endtask

   task automatic pop(input int sel);
      rd_en_v[sel] = 1'b1;
      @(negedge clk);
      rd_en_v[sel] = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      baud_div = 16'd3;
      clr_err  = 1'b0;
      rxd_v    = '1;
      rd_en_v  = '0;

      //             sel data   par  pb    s0    s1    2stp  exp    pe    fe
      vecs[0] = mk(0, 8'hA5, 0, 1'b0, 1'b1, 1'b1, 0, 8'hA5, 1'b0, 1'b0);
      vecs[1] = mk(0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0);
      vecs[2] = mk(0, 8'h55, 0, 1'b0, 1'b0, 1'b1, 0, 8'h55, 1'b0, 1'b1);
      vecs[3] = mk(1, 8'h0F, 1, 1'b1, 1'b1, 1'b1, 0, 8'h0F, 1'b1, 1'b0);
      vecs[4] = mk(1, 8'h0F, 1, 1'b0, 1'b1, 1'b1, 0, 8'h0F, 1'b0, 1'b0);
      vecs[5] = mk(1, 8'h07, 1, 1'b0, 1'b1, 1'b1, 0, 8'h07, 1'b1, 1'b0);
      vecs[6] = mk(1, 8'h81, 1, 1'b0, 1'b0, 1'b1, 0, 8'h81, 1'b0, 1'b1);
      vecs[7] = mk(2, 8'h55, 0, 1'b0, 1'b1, 1'b0, 1, 8'h55, 1'b0, 1'b1);
      vecs[8] = mk(2, 8'hC3, 0, 1'b0, 1'b1, 1'b1, 1, 8'hC3, 1'b0, 1'b0);

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         check($sformatf("rst%0d rdr", s),   rdr_v[s],   8'h00);
         check($sformatf("rst%0d ready", s), ready_v[s], 1'b0);
         check($sformatf("rst%0d flags", s), {ovr_v[s], fe_v[s], pe_v[s]}, 3'b000);
         check($sformatf("rst%0d count", s), cnt_v[s],   3'd0);
      end
      repeat (20) @(negedge clk);

      // Single frames: receive, inspect head, pop, confirm empty
      for (int i = 0; i < 9; i++) begin
         send_frame(vecs[i].sel, vecs[i].data, vecs[i].par_en, vecs[i].par_bit,
                    vecs[i].stop0, vecs[i].stop1, vecs[i].two_stop, -1);
         check($sformatf("v%0d rdr", i),   rdr_v[vecs[i].sel],   vecs[i].exp_rdr);
         check($sformatf("v%0d pe", i),    pe_v[vecs[i].sel],    vecs[i].exp_pe);
         check($sformatf("v%0d fe", i),    fe_v[vecs[i].sel],    vecs[i].exp_fe);
         check($sformatf("v%0d ready", i), ready_v[vecs[i].sel], 1'b1);
         check($sformatf("v%0d count", i), cnt_v[vecs[i].sel],   3'd1);
         pop(vecs[i].sel);
         check($sformatf("v%0d pop ready", i), ready_v[vecs[i].sel], 1'b0);
         check($sformatf("v%0d pop rdr", i),   rdr_v[vecs[i].sel],   8'h00);
         check($sformatf("v%0d pop count", i), cnt_v[vecs[i].sel],   3'd0);
      end

      // False start: 20-cycle low pulse is rejected
      rxd_v[0] = 1'b0;
      repeat (20) @(negedge clk);
      rxd_v[0] = 1'b1;
      repeat (200) @(negedge clk);
      check("false start count", cnt_v[0],   3'd0);
      check("false start ready", ready_v[0], 1'b0);

      // Glitch at bit-3 centre of 0xFF touches one sample only
      send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
      check("glitch rdr", rdr_v[0], 8'hFF);
      check("glitch fe",  fe_v[0],  1'b0);
      pop(0);

      // Overrun: five words into a four-entry queue
      for (int i = 0; i < 4; i++) send_8n1(8'((i + 1) * 8'h11));
      check("fill count",   cnt_v[0], 3'd4);
      check("fill overrun", ovr_v[0], 1'b0);
      send_8n1(8'h55);
      check("ovr count",   cnt_v[0], 3'd4);
      check("ovr overrun", ovr_v[0], 1'b1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovr pop%0d rdr", i), rdr_v[0], 8'((i + 1) * 8'h11));
         pop(0);
      end
      check("ovr drained count", cnt_v[0], 3'd0);
      check("ovr drained ready", ready_v[0], 1'b0);
      check("ovr sticky",        ovr_v[0], 1'b1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("ovr cleared", ovr_v[0], 1'b0);

      // Reset mid-frame: queued word and partial frame both discarded
      send_8n1(8'h99);
      check("pre-rst count", cnt_v[0], 3'd1);
      drive_bit(0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(0, 1'(8'hAA >> i), 1'b0);
      rxd_v[0] = 1'b1;
      repeat (BIT_CYC / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst rdr",   rdr_v[0],   8'h00);
      check("midrst ready", ready_v[0], 1'b0);
      check("midrst flags", {ovr_v[0], fe_v[0], pe_v[0]}, 3'b000);
      check("midrst count", cnt_v[0],   3'd0);
      repeat (10 * BIT_CYC) @(negedge clk);
      check("midrst idle count", cnt_v[0], 3'd0);
      send_8n1(8'h3C);
      check("post-rst rdr",   rdr_v[0],   8'h3C);
      check("post-rst flags", {fe_v[0], pe_v[0]}, 2'b00);
      check("post-rst count", cnt_v[0],   3'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised successor to the single-word UART receiver. Receives asynchronous serial frames on `rxd` with a runtime-programmable baud divisor, configurable data width, parity and stop bits. Each bit is oversampled with a 3-sample majority vote, framing and parity are checked, and received words are queued in a small first-word-fall-through FIFO with overrun detection. Sits between the pad-side `rxd` line and the host register interface, in the `sysclk` domain.

## Interface
- `data_bits`, 8: payload bits per frame (5..9).
- `oversample`, 16: sample ticks per bit; even, ≥ 4.
- `div_bits`, 16: width of `baud_div`.
- `parity_mode`, 0: 0 = none, 1 = even, 2 = odd.
- `stop_bits`, 1: 1 or 2.
- `fifo_depth`, 4: receive FIFO entries; power of 2, ≥ 2.

- `sysclk` in 1: system clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rxd` in 1: asynchronous serial input, idle high.
- `baud_div` in div_bits: sample tick period is baud_div+1 sysclk cycles. Change only while idle.
- `rd_en` in 1: pop the FIFO head. Ignored when empty.
- `clr_err` in 1: clears sticky `overrun`.
- `RDR` out data_bits: FIFO head data.
- `rxd_readyH` out 1: FIFO non-empty.
- `parity_err` out 1: parity error flag of the head entry. 0 when `parity_mode` = 0.
- `frame_err` out 1: stop-bit error flag of the head entry.
- `overrun` out 1: sticky. Set when a completed word is dropped because the FIFO is full.
- `fifo_count` out clog2(fifo_depth)+1: number of entries.

## Operation
- **Input synchroniser.** `rxd` passes through 2 flops, both reset to 1. All logic uses the synchronised value.
- **Tick generator.**
  - Down-counter reloads to `baud_div` and emits a 1-cycle `tick` at 0.
  - Free-running in IDLE.
  - Realigned (reloaded) on start-edge detection.
- **Bit timing.**
  - A sample counter of 0..oversample-1 ticks runs per bit.
  - The bit value is the majority of synchronised samples at ticks oversample/2-1, oversample/2 and oversample/2+1.
  - The bit is decided at tick oversample/2+1.
- **FSM.**
  - IDLE: on a synchronised 1→0 edge, go to START.
  - START: at the decision point, if the majority is 1 (false start), go to IDLE. Otherwise go to DATA.
  - DATA: shift `data_bits` bits LSB first, then go to PARITY (if `parity_mode` ≠ 0) or STOP.
  - PARITY: compute `pe`:
    - Even mode: pe = XOR(data, parity bit) ≠ 0.
    - Odd mode: pe = XOR(data, parity bit) ≠ 1.
  - STOP: each stop bit must be 1, else `fe` = 1. After the last stop bit's decision, push {fe, pe, data} and go to IDLE. A new start edge is accepted from the next cycle.
- **Errored words.** Words with `fe` or `pe` set are still pushed; their flags travel with them.
- **FIFO push/pop.**
  - Push is accepted if not full, or if `rd_en` pops in the same cycle.
  - Otherwise the word is dropped and `overrun` is set.
  - Simultaneous push and pop on a non-empty FIFO leaves `fifo_count` unchanged.
- **FIFO pointers.** Wrap modulo `fifo_depth`.
- **Sticky overrun.** `overrun` set and `clr_err` in the same cycle leaves it set.

## Timing
- **Reset values.** On `rst`, on the next edge:
  - FSM goes to IDLE; counters clear; FIFO empties.
  - `RDR` = 0; `rxd_readyH`, `parity_err`, `frame_err`, `overrun` = 0; `fifo_count` = 0.
  - Synchroniser flops = 1.
  - A frame in progress is discarded.
- **Edge detection latency.** 2 cycles after `rxd` falls (synchroniser).
- **Output latency.**
  - `rxd_readyH`, `RDR` and the flags update 1 cycle after the push cycle.
  - Push occurs in the cycle after the final stop-bit decision tick.
- **Pop.** `RDR` and the flags show the next entry (or 0 when emptied) 1 cycle after `rd_en`.
- **Bit period.** oversample × (baud_div+1) cycles. Receiver tolerates ±(oversample/2−2)/oversample of a bit of cumulative drift at the stop bit.
- **Glitch rejection.** A `rxd` glitch shorter than 1 tick, touching one sampling tick, does not change the decided bit.

## Test plan
1. **8N1 word.** `baud_div`=3, `oversample`=16 (64-cycle bits); send 0xA5 8N1 → `RDR`=0xA5, `rxd_readyH`=1, both error flags 0, `fifo_count`=1. `rd_en` → `rxd_readyH`=0, `RDR`=0.
2. **False start and glitch.** Low pulse of 20 cycles on idle line → no push, FSM back in IDLE. Single 4-cycle low glitch at bit-3 centre of 0xFF → `RDR`=0xFF.
3. **Parity error.** `parity_mode`=1; send 0x0F with parity bit 1 → `RDR`=0x0F, `parity_err`=1. Correct parity bit 0 → `parity_err`=0.
4. **Framing error.** Send 0x55 with stop bit held 0 → `RDR`=0x55, `frame_err`=1. With `stop_bits`=2, second stop 0 → `frame_err`=1.
5. **Overrun.** `fifo_depth`=4; send 0x11, 0x22, 0x33, 0x44, 0x55 without pops → `fifo_count`=4, `overrun`=1. Four pops yield 0x11..0x44 in order. `clr_err` clears `overrun`.
6. **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 3 → all outputs 0. Next clean frame 0x3C → `RDR`=0x3C, no errors.
